// File: rtl/fpu_csr_mc.sv
// rtl/fpu_csr_mc.sv - multi-lane FP CSR block (fflags/frm/fcsr); FS tracking under FPU_CSR_FS_TRACK_EN
module fpu_csr_mc #(
    parameter int         NUM_CH  = 2,
    parameter logic [2:0] RST_FRM = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_valid,
    input  logic [1:0]            csr_op,
    input  logic [11:0]           csr_addr,
    input  logic [31:0]           csr_wdata,
    output logic [31:0]           csr_rdata,
    output logic                  csr_rvalid,
    output logic                  csr_illegal,
    input  logic [NUM_CH-1:0]     ch_flags_valid,
    input  logic [5*NUM_CH-1:0]   ch_flags,
    input  logic [3*NUM_CH-1:0]   ch_inst_rm,
    output logic [3*NUM_CH-1:0]   ch_eff_rm,
    output logic [NUM_CH-1:0]     ch_rm_illegal,
    input  logic                  fs_wr,
    input  logic [1:0]            fs_wdata,
    input  logic                  fp_rf_write,
    output logic [1:0]            fs_out,
    output logic [2:0]            frm_out,
    output logic [4:0]            fflags_out
);
    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;

    logic [2:0]  r_frm;
    logic [4:0]  r_fflags;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_illegal;

    logic [4:0]  w_in_flags;
    logic [4:0]  w_merged;
    logic        w_fs_off;
    logic        w_addr_ok;
    logic        w_illegal;
    logic        w_hit_ff;
    logic        w_hit_frm;
    logic [2:0]  w_frm_opnd;
    logic [4:0]  w_fflags_nxt;
    logic [2:0]  w_frm_nxt;
    logic [31:0] w_rd;
    logic        w_unused_wdata;

    assign w_unused_wdata = ^csr_wdata[31:8];

    always_comb begin
        w_in_flags = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_flags_valid[i]) w_in_flags = w_in_flags | ch_flags[5*i +: 5];
        end
    end

`ifdef FPU_CSR_FS_TRACK_EN
    typedef enum logic [1:0] {
        FS_OFF     = 2'b00,
        FS_INITIAL = 2'b01,
        FS_CLEAN   = 2'b10,
        FS_DIRTY   = 2'b11
    } fs_t;

    fs_t r_fs;
    fs_t w_fs_nxt;

    assign w_fs_off = (r_fs == FS_OFF);
    assign fs_out   = r_fs;

    // An explicit FS write beats any dirtying event in the same cycle
    always_comb begin
        w_fs_nxt = r_fs;
        if (fs_wr) begin
            w_fs_nxt = fs_t'(fs_wdata);
        end else if (!w_fs_off && ((w_fflags_nxt != r_fflags) || (w_frm_nxt != r_frm) || fp_rf_write)) begin
            w_fs_nxt = FS_DIRTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fs <= FS_OFF;
        else        r_fs <= w_fs_nxt;
    end
`else
    logic w_unused_fs;
    assign w_unused_fs = ^{fs_wr, fs_wdata, fp_rf_write};
    assign w_fs_off    = 1'b0;
    assign fs_out      = 2'b11;
`endif

    // Same-cycle lane flags are older than the CSR access
    assign w_merged   = r_fflags | (w_fs_off ? 5'd0 : w_in_flags);
    assign w_addr_ok  = (csr_addr == ADDR_FFLAGS) || (csr_addr == ADDR_FRM) || (csr_addr == ADDR_FCSR);
    assign w_illegal  = csr_valid && (!w_addr_ok || w_fs_off);
    assign w_hit_ff   = csr_valid && !w_illegal && (csr_addr != ADDR_FRM);
    assign w_hit_frm  = csr_valid && !w_illegal && (csr_addr != ADDR_FFLAGS);
    assign w_frm_opnd = (csr_addr == ADDR_FCSR) ? csr_wdata[7:5] : csr_wdata[2:0];

    always_comb begin
        w_fflags_nxt = w_merged;
        w_frm_nxt    = r_frm;
        if (w_hit_ff) begin
            case (csr_op)
                2'b00:   w_fflags_nxt = csr_wdata[4:0];
                2'b01:   w_fflags_nxt = w_merged | csr_wdata[4:0];
                2'b10:   w_fflags_nxt = w_merged & ~csr_wdata[4:0];
                default: w_fflags_nxt = w_merged;
            endcase
        end
        if (w_hit_frm) begin
            case (csr_op)
                2'b00:   w_frm_nxt = w_frm_opnd;
                2'b01:   w_frm_nxt = r_frm | w_frm_opnd;
                2'b10:   w_frm_nxt = r_frm & ~w_frm_opnd;
                default: w_frm_nxt = r_frm;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        if (csr_valid && !w_illegal) begin
            case (csr_addr)
                ADDR_FFLAGS: w_rd = {27'd0, w_merged};
                ADDR_FRM:    w_rd = {29'd0, r_frm};
                ADDR_FCSR:   w_rd = {24'd0, r_frm, w_merged};
                default:     w_rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm     <= RST_FRM;
            r_fflags  <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_frm     <= w_frm_nxt;
            r_fflags  <= w_fflags_nxt;
            r_rdata   <= w_rd;
            r_rvalid  <= csr_valid;
            r_illegal <= w_illegal;
        end
    end

    // Lanes resolve dynamic rm against the currently stored frm
    always_comb begin
        ch_eff_rm     = '0;
        ch_rm_illegal = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_eff_rm[3*i +: 3] = (ch_inst_rm[3*i +: 3] == 3'b111) ? r_frm : ch_inst_rm[3*i +: 3];
            ch_rm_illegal[i]    = (ch_eff_rm[3*i +: 3] >= 3'd5);
        end
    end

    assign csr_rdata   = r_rdata;
    assign csr_rvalid  = r_rvalid;
    assign csr_illegal = r_illegal;
    assign frm_out     = r_frm;
    assign fflags_out  = r_fflags;

endmodule

// File: tb/tb_fpu_csr_mc.sv
// tb/tb_fpu_csr_mc.sv - randomized self-checking bench for fpu_csr_mc against a behavioural model
module tb_fpu_csr_mc;
    localparam int N = 2;
`ifdef FPU_CSR_FS_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic csr_valid;
    logic [1:0] csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic csr_rvalid, csr_illegal;
    logic [N-1:0] ch_flags_valid;
    logic [5*N-1:0] ch_flags;
    logic [3*N-1:0] ch_inst_rm;
    logic [3*N-1:0] ch_eff_rm;
    logic [N-1:0] ch_rm_illegal;
    logic fs_wr;
    logic [1:0] fs_wdata;
    logic fp_rf_write;
    logic [1:0] fs_out;
    logic [2:0] frm_out;
    logic [4:0] fflags_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] m_ff;
    logic [2:0] m_frm;
    logic [1:0] m_fs;
    logic [31:0] e_rdata;
    logic e_rvalid, e_ill;

    always #5 clk = ~clk;

    fpu_csr_mc #(.NUM_CH(N), .RST_FRM(3'b000)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_illegal(csr_illegal),
        .ch_flags_valid(ch_flags_valid), .ch_flags(ch_flags), .ch_inst_rm(ch_inst_rm),
        .ch_eff_rm(ch_eff_rm), .ch_rm_illegal(ch_rm_illegal),
        .fs_wr(fs_wr), .fs_wdata(fs_wdata), .fp_rf_write(fp_rf_write),
        .fs_out(fs_out), .frm_out(frm_out), .fflags_out(fflags_out)
    );

    function automatic logic [4:0] apply_op(input logic [1:0] op, input logic [4:0] old, input logic [4:0] w);
        case (op)
            2'd0:    return w;
            2'd1:    return old | w;
            2'd2:    return old & ~w;
            default: return old;
        endcase
    endfunction

    function automatic void model_reset();
        m_ff  = 5'd0;
        m_frm = 3'd0;
        m_fs  = TRACK ? 2'b00 : 2'b11;
    endfunction

    // One clock of the reference: computes the response of this cycle's inputs and the next state
    function automatic void model_step(input bit v, input logic [1:0] op, input logic [11:0] addr,
                                       input logic [31:0] wd, input logic [N-1:0] lv,
                                       input logic [5*N-1:0] lf, input bit fswr,
                                       input logic [1:0] fswd, input bit rfw);
        logic [4:0] inf, cur, nff;
        logic [2:0] nfrm, frmop;
        bit off, bad;
        inf = 5'd0;
        for (int i = 0; i < N; i++) if (lv[i]) inf = inf | lf[5*i +: 5];
        off = TRACK && (m_fs == 2'b00);
        if (off) inf = 5'd0;
        cur  = m_ff | inf;
        bad  = !(addr == 12'h001 || addr == 12'h002 || addr == 12'h003);
        e_rvalid = v;
        e_ill    = v && (bad || off);
        e_rdata  = 32'd0;
        nff  = cur;
        nfrm = m_frm;
        if (v && !e_ill) begin
            if (addr == 12'h001)      e_rdata = 32'(cur);
            else if (addr == 12'h002) e_rdata = 32'(m_frm);
            else                      e_rdata = 32'(m_frm) * 32 + 32'(cur);
            frmop = (addr == 12'h003) ? wd[7:5] : wd[2:0];
            if (addr != 12'h002) nff = apply_op(op, cur, wd[4:0]);
            if (addr != 12'h001) begin
                logic [4:0] t;
                t = apply_op(op, {2'b00, m_frm}, {2'b00, frmop});
                nfrm = t[2:0];
            end
        end
        if (TRACK) begin
            if (fswr) m_fs = fswd;
            else if (!off && ((nff != m_ff) || (nfrm != m_frm) || rfw)) m_fs = 2'b11;
        end
        m_ff  = nff;
        m_frm = nfrm;
    endfunction

    task automatic cycle(input bit v, input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [N-1:0] lv, input logic [5*N-1:0] lf,
                         input bit fswr, input logic [1:0] fswd, input bit rfw);
        csr_valid = v; csr_op = op; csr_addr = addr; csr_wdata = wd;
        ch_flags_valid = lv; ch_flags = lf;
        fs_wr = fswr; fs_wdata = fswd; fp_rf_write = rfw;
        model_step(v, op, addr, wd, lv, lf, fswr, fswd, rfw);
        @(posedge clk);
        #1;
        csr_valid = 1'b0; ch_flags_valid = '0; fs_wr = 1'b0; fp_rf_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        ch_flags_valid = 0; ch_flags = 0; ch_inst_rm = 0;
        fs_wr = 0; fs_wdata = 0; fp_rf_write = 0;
        model_reset();
        #12;
        n_cmp++; if (frm_out !== 3'd0) begin $display("FAIL reset_frm got %0h want 0", frm_out); n_err++; end
        n_cmp++; if (fflags_out !== 5'd0) begin $display("FAIL reset_fflags got %0h want 0", fflags_out); n_err++; end
        n_cmp++; if (csr_rvalid !== 1'b0 || csr_illegal !== 1'b0 || csr_rdata !== 32'd0) begin
            $display("FAIL reset_resp got v=%b i=%b d=%0h want 0/0/0", csr_rvalid, csr_illegal, csr_rdata); n_err++; end
        n_cmp++; if (fs_out !== m_fs) begin $display("FAIL reset_fs got %0d want %0d", fs_out, m_fs); n_err++; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_csr_read();
        if (TRACK) cycle(0, 0, 0, 0, '0, '0, 1, 2'b11, 0);
        cycle(1, 2'b01, 12'h003, 32'd0, '0, '0, 0, 0, 0);
        n_cmp++; if (csr_rdata !== 32'd0 || csr_rvalid !== 1'b1 || csr_illegal !== 1'b0) begin
            $display("FAIL read_fcsr got d=%0h v=%b i=%b want 0/1/0", csr_rdata, csr_rvalid, csr_illegal); n_err++; end
        n_cmp++; if (frm_out !== 3'd0) begin $display("FAIL read_frm got %0d want 0", frm_out); n_err++; end
        @(posedge clk); #1;
        n_cmp++; if (csr_rvalid !== 1'b0) begin $display("FAIL rvalid_pulse got %b want 0", csr_rvalid); n_err++; end
    endtask

    task automatic test_lane_merge();
        cycle(0, 0, 0, 0, 2'b11, {5'b10000, 5'b00001}, 0, 0, 0);
        n_cmp++; if (fflags_out !== 5'b10001) begin $display("FAIL lane_merge got %b want 10001", fflags_out); n_err++; end
        cycle(0, 0, 0, 0, 2'b01, {5'b01000, 5'b00010}, 0, 0, 0);
        n_cmp++; if (fflags_out !== 5'b10011) begin $display("FAIL lane_invalid got %b want 10011", fflags_out); n_err++; end
    endtask

    task automatic test_ordering();
        cycle(1, 2'b00, 12'h001, 32'd0, '0, '0, 0, 0, 0);
        cycle(1, 2'b00, 12'h001, 32'd0, 2'b01, {5'b00000, 5'b00100}, 0, 0, 0);
        n_cmp++; if (csr_rdata !== 32'h4) begin $display("FAIL order_rdata got %0h want 4", csr_rdata); n_err++; end
        n_cmp++; if (fflags_out !== 5'd0) begin $display("FAIL order_fflags got %b want 0", fflags_out); n_err++; end
    endtask

    task automatic test_rm();
        cycle(1, 2'b00, 12'h002, 32'd7, '0, '0, 0, 0, 0);
        n_cmp++; if (frm_out !== 3'd7) begin $display("FAIL rm_store got %0d want 7", frm_out); n_err++; end
        ch_inst_rm = {3'd1, 3'd7}; #1;
        n_cmp++; if (ch_eff_rm[2:0] !== 3'd7 || ch_rm_illegal[0] !== 1'b1) begin
            $display("FAIL rm_dyn got %0d/%b want 7/1", ch_eff_rm[2:0], ch_rm_illegal[0]); n_err++; end
        n_cmp++; if (ch_eff_rm[5:3] !== 3'd1 || ch_rm_illegal[1] !== 1'b0) begin
            $display("FAIL rm_static got %0d/%b want 1/0", ch_eff_rm[5:3], ch_rm_illegal[1]); n_err++; end
        ch_inst_rm = {3'd5, 3'd4}; #1;
        n_cmp++; if (ch_rm_illegal !== 2'b10) begin $display("FAIL rm_bound got %b want 10", ch_rm_illegal); n_err++; end
    endtask

    task automatic test_fs();
`ifdef FPU_CSR_FS_TRACK_EN
        cycle(0, 0, 0, 0, '0, '0, 1, 2'b01, 0);
        n_cmp++; if (fs_out !== 2'b01) begin $display("FAIL fs_load got %0d want 1", fs_out); n_err++; end
        cycle(1, 2'b10, 12'h003, 32'd0, '0, '0, 0, 0, 0);
        n_cmp++; if (fs_out !== 2'b01) begin $display("FAIL fs_noop got %0d want 1", fs_out); n_err++; end
        cycle(1, 2'b00, 12'h002, 32'd1, '0, '0, 0, 0, 0);
        n_cmp++; if (fs_out !== 2'b11) begin $display("FAIL fs_dirty got %0d want 3", fs_out); n_err++; end
        cycle(0, 0, 0, 0, '0, '0, 1, 2'b10, 1);
        n_cmp++; if (fs_out !== 2'b10) begin $display("FAIL fs_prio got %0d want 2", fs_out); n_err++; end
        cycle(0, 0, 0, 0, '0, '0, 0, 0, 1);
        n_cmp++; if (fs_out !== 2'b11) begin $display("FAIL fs_rfw got %0d want 3", fs_out); n_err++; end
        cycle(0, 0, 0, 0, '0, '0, 1, 2'b00, 0);
        cycle(1, 2'b00, 12'h003, 32'hFF, 2'b11, {5'b11111, 5'b11111}, 0, 0, 1);
        n_cmp++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'd0) begin
            $display("FAIL fs_off_trap got i=%b d=%0h want 1/0", csr_illegal, csr_rdata); n_err++; end
        n_cmp++; if (frm_out !== m_frm || fflags_out !== m_ff || fs_out !== 2'b00) begin
            $display("FAIL fs_off_state got %0d/%b/%0d want %0d/%b/0", frm_out, fflags_out, fs_out, m_frm, m_ff); n_err++; end
`else
        cycle(0, 0, 0, 0, '0, '0, 1, 2'b00, 1);
        n_cmp++; if (fs_out !== 2'b11) begin $display("FAIL fs_const got %0d want 3", fs_out); n_err++; end
`endif
    endtask

    task automatic test_illegal();
        logic [2:0] frm_before;
        frm_before = m_frm;
        cycle(1, 2'b00, 12'h004, 32'hFF, '0, '0, 0, 0, 0);
        n_cmp++; if (csr_illegal !== 1'b1 || csr_rvalid !== 1'b1 || csr_rdata !== 32'd0) begin
            $display("FAIL bad_addr got i=%b v=%b d=%0h want 1/1/0", csr_illegal, csr_rvalid, csr_rdata); n_err++; end
        n_cmp++; if (frm_out !== frm_before) begin $display("FAIL bad_addr_frm got %0d want %0d", frm_out, frm_before); n_err++; end
    endtask

    task automatic test_back_to_back();
        if (TRACK) cycle(0, 0, 0, 0, '0, '0, 1, 2'b11, 0);
        cycle(1, 2'b00, 12'h003, 32'hFFFF_FFAB, '0, '0, 0, 0, 0);
        cycle(1, 2'b01, 12'h003, 32'd0, '0, '0, 0, 0, 0);
        n_cmp++; if (csr_rdata !== 32'hAB) begin $display("FAIL b2b_fcsr got %0h want ab", csr_rdata); n_err++; end
        cycle(1, 2'b10, 12'h001, 32'h3, '0, '0, 0, 0, 0);
        n_cmp++; if (csr_rdata !== 32'h0B || fflags_out !== 5'h08) begin
            $display("FAIL b2b_clear got %0h/%0h want b/8", csr_rdata, fflags_out); n_err++; end
        cycle(1, 2'b11, 12'h002, 32'h0, '0, '0, 0, 0, 0);
        n_cmp++; if (csr_rdata !== 32'h5 || frm_out !== 3'd5) begin
            $display("FAIL b2b_frm got %0h/%0d want 5/5", csr_rdata, frm_out); n_err++; end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [11:0] a;
            int r;
            r = $urandom_range(0, 7);
            a = (r < 6) ? 12'(r % 3 + 1) : ((r == 6) ? 12'h000 : 12'($urandom_range(4, 4095)));
            ch_inst_rm = 6'($urandom);
            #1;
            for (int i = 0; i < N; i++) begin
                logic [2:0] er;
                er = (ch_inst_rm[3*i +: 3] == 3'd7) ? m_frm : ch_inst_rm[3*i +: 3];
                n_cmp++; if (ch_eff_rm[3*i +: 3] !== er || ch_rm_illegal[i] !== (er >= 3'd5)) begin
                    $display("FAIL rnd_rm lane%0d got %0d/%b want %0d/%b", i, ch_eff_rm[3*i +: 3], ch_rm_illegal[i], er, er >= 3'd5); n_err++; end
            end
            cycle($urandom_range(0, 1), 2'($urandom), a, $urandom, N'($urandom), (5*N)'($urandom),
                  $urandom_range(0, 7) == 0, 2'($urandom), $urandom_range(0, 3) == 0);
            n_cmp++; if (csr_rvalid !== e_rvalid || csr_illegal !== e_ill || csr_rdata !== e_rdata) begin
                $display("FAIL rnd_resp it%0d got v=%b i=%b d=%0h want v=%b i=%b d=%0h", k,
                         csr_rvalid, csr_illegal, csr_rdata, e_rvalid, e_ill, e_rdata); n_err++; end
            n_cmp++; if (frm_out !== m_frm || fflags_out !== m_ff || fs_out !== m_fs) begin
                $display("FAIL rnd_state it%0d got frm=%0d ff=%b fs=%0d want frm=%0d ff=%b fs=%0d", k,
                         frm_out, fflags_out, fs_out, m_frm, m_ff, m_fs); n_err++; end
        end
    endtask

    task automatic test_async_reset();
        if (TRACK) cycle(0, 0, 0, 0, '0, '0, 1, 2'b11, 0);
        cycle(1, 2'b00, 12'h003, 32'hFF, '0, '0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (csr_rvalid !== 1'b0 || frm_out !== 3'd0 || fflags_out !== 5'd0 || fs_out !== m_fs) begin
            $display("FAIL async_reset got v=%b frm=%0d ff=%b fs=%0d want 0/0/0/%0d",
                     csr_rvalid, frm_out, fflags_out, fs_out, m_fs); n_err++; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_csr_read();
        test_lane_merge();
        test_ordering();
        test_rm();
        test_fs();
        test_illegal();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_csr_mc.md
# fpu_csr_mc

Multi-channel floating-point CSR block holding `fflags`, `frm` and `fcsr` for a core that retires up to `NUM_CH` FP operations per cycle. It accumulates sticky exception flags from every retiring FPU lane and orders them against Zicsr accesses. It resolves the dynamic rounding mode per lane and, optionally, tracks the `mstatus.FS` context state. It sits between the FP execute/retire stage and the integer CSR unit, replacing the single-lane FP CSR.

## Interface
- `NUM_CH`, 2: number of FPU flag/rounding channels (1..8).
- `RST_FRM`, 3'b000: `frm` reset value (RNE).
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `csr_valid` input 1: CSR access request, one cycle per access.
- `csr_op` input 2: 00=CSRRW, 01=CSRRS, 10=CSRRC, 11=read-only (no write).
- `csr_addr` input 12: 0x001 `fflags`, 0x002 `frm`, 0x003 `fcsr`.
- `csr_wdata` input 32: write/set/clear operand.
- `csr_rdata` output 32: pre-access value, registered.
- `csr_rvalid` output 1: `csr_rdata` valid, one-cycle pulse.
- `csr_illegal` output 1: access rejected, one-cycle pulse aligned with `csr_rvalid`.
- `ch_flags_valid` input NUM_CH: lane i retired an FP op this cycle.
- `ch_flags` input 5*NUM_CH: lane i flags {NV,DZ,OF,UF,NX} at [5i+4:5i].
- `ch_inst_rm` input 3*NUM_CH: lane i instruction rm field.
- `ch_eff_rm` output 3*NUM_CH: lane i resolved rounding mode.
- `ch_rm_illegal` output NUM_CH: lane i rounding mode invalid.
- `fs_wr` input 1: mstatus.FS write strobe.
- `fs_wdata` input 2: new FS value.
- `fp_rf_write` input 1: FP register file written this cycle.
- `fs_out` output 2: current FS state.
- `frm_out` output 3: current `frm`.
- `fflags_out` output 5: current `fflags`.

## Operation
- Storage: `frm_q` 3b, `fflags_q` 5b; `fcsr` read = {24'd0, frm_q, fflags_q}; `frm`/`fflags` reads zero-extended.
- Lane merge: `in_flags` = OR over all i with `ch_flags_valid[i]` of that lane's flags; a lane with valid low contributes nothing.
- Ordering: lane flags in the same cycle as a CSR access are older than the access. The access reads and operates on `fflags_q | in_flags`.
- Update: `fflags_d` = op(`fflags_q | in_flags`, wdata[4:0]). For frm, `frm_d` = op(`frm_q`, wdata[2:0]). For `fcsr`, the fields come from wdata[7:5]/[4:0]. wdata bits above the field are ignored.
- CSRRS/CSRRC with wdata field 0 still reads; it does not change the value and does not mark FS dirty.
- Reserved `frm` values 5,6 and 7 are stored as written.
- Illegal address, or FS=OFF (when tracked), raises `csr_illegal`. An illegal access causes no state change, and `csr_rdata` returns 0. Lane flags are still merged unless FS=OFF.
- Rounding resolution, per lane and combinational: `ch_eff_rm` = `ch_inst_rm` unless it equals 3'b111, in which case it is `frm_q`. `ch_rm_illegal` is high when the effective value is 5, 6 or 7. A lane resolves against `frm_q` before any same-cycle CSR write.
- FS machine, compiled in by macro: states OFF=00, INITIAL=01, CLEAN=10, DIRTY=11.
  - Priority: `fs_wr` loads `fs_wdata`.
  - Otherwise, any change to `fflags_q`/`frm_q`, or `fp_rf_write`, moves the state to DIRTY.
  - In OFF, lane flags and `fp_rf_write` are ignored.

## Timing
- Reset: `frm_q`=`RST_FRM`, `fflags_q`=0, `csr_rdata`=0, `csr_rvalid`=0, `csr_illegal`=0, `fs_out`=OFF (macro) or DIRTY (no macro).
- CSR access is accepted every cycle (no backpressure). `csr_rdata`/`csr_rvalid`/`csr_illegal` appear in cycle N+1, and the new value is visible in `frm_out`/`fflags_out` in N+1.
- Back-to-back accesses: the access in N+1 sees the result of the access in N.
- Lane flags sampled in cycle N are visible in `fflags_out` in N+1.
- `fs_wr` and a dirtying event in the same cycle: `fs_wr` wins.
- Reset mid-operation clears all state asynchronously, and a pending `csr_rvalid` is dropped.

## Configuration
- `FPU_CSR_FS_TRACK_EN` defined: FS state machine present, OFF-state access trapping active, OFF-state lane flags ignored.
- `FPU_CSR_FS_TRACK_EN` undefined: `fs_out` is constant 2'b11, the `fs_*` and `fp_rf_write` inputs are ignored, and `csr_illegal` is raised only for bad addresses.

## Test plan
- Reset, then CSRRS 0x003 with wdata 0 -> next cycle `csr_rdata`=0, `csr_rvalid`=1, `frm_out`=0.
- Lanes 0 and 1 flags 5'b00001 and 5'b10000 in the same cycle -> `fflags_out`=5'b10001 next cycle.
- Lane 0 flag OF with CSRRW 0x001 wdata 0 in the same cycle -> `csr_rdata`=5'b00100, `fflags_out`=0.
- CSRRW 0x002 wdata 7, then a lane with `ch_inst_rm`=7 -> `ch_eff_rm`=7, `ch_rm_illegal`=1; with `ch_inst_rm`=1 -> 1, 0.
- Macro on: `fs_wr` 01, then CSRRC 0x003 wdata 0 -> FS stays 01; then CSRRW 0x002 wdata 1 -> FS=11.
- Macro on, FS=00: CSRRW 0x003 wdata 0xFF -> `csr_illegal`=1, `fcsr` unchanged. Access to 0x004 -> `csr_illegal`=1, `csr_rdata`=0.
